// File: rtl/oram_fetch_path.sv
// oram_fetch_path: ORAM read path - position-map lookup, root-to-leaf bucket walk, invalidate matches, remap leaf.
// Define ORAM_FETCH_STATS_EN to add saturating stat_hits/stat_misses counters.
module oram_fetch_path #(
    parameter int BYTE_WIDTH = 8,
    parameter int BYTES_PER_BLOCK = 4,
    parameter int TREE_DEPTH = 6,
    parameter int K = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int VAL_W = BYTE_WIDTH * BYTES_PER_BLOCK,
    localparam int TUPLE_W = VAL_W + 2 * TREE_DEPTH + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [TREE_DEPTH-1:0]   req_block,
    output logic                    pm_rd_en,
    output logic [TREE_DEPTH-1:0]   pm_addr,
    input  logic [TREE_DEPTH-1:0]   pm_rdata,
    output logic                    pm_wr_en,
    output logic [TREE_DEPTH-1:0]   pm_wdata,
    output logic                    bkt_rd_en,
    output logic                    bkt_wr_en,
    output logic [TREE_DEPTH-1:0]   bkt_addr,
    input  logic [K*TUPLE_W-1:0]    bkt_rdata,
    output logic [K*TUPLE_W-1:0]    bkt_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_hit,
    output logic [VAL_W-1:0]        rsp_val,
    output logic [TREE_DEPTH-1:0]   rsp_block,
    output logic [TREE_DEPTH-2:0]   rsp_new_pos
`ifdef ORAM_FETCH_STATS_EN
    ,
    output logic [15:0]             stat_hits,
    output logic [15:0]             stat_misses
`endif
);
    localparam int BN_LSB = VAL_W + 2;
    localparam int PE_BIT = BN_LSB + TREE_DEPTH;
    localparam int POS_LSB = PE_BIT + 1;
    localparam int LW = $clog2(TREE_DEPTH);
    localparam logic [LW-1:0] LAST = LW'(TREE_DEPTH - 1);
    localparam logic [TREE_DEPTH-1:0] ROOT = 1;

    typedef enum logic [2:0] {IDLE, PM_RD, PM_DATA, BKT_RD, BKT_CMP, PM_WR, RESP} state_t;

    state_t state;
    logic [15:0] lfsr;
    logic [TREE_DEPTH-2:0] leaf;
    logic [TREE_DEPTH-1:0] node, node_n;
    logic [LW-1:0] level;
    logic assigned;
    logic [K-1:0] match;
    logic [VAL_W-1:0] first_val;
    logic [K*TUPLE_W-1:0] wdata;

    assign req_ready = state == IDLE;
    assign pm_wdata = {rsp_new_pos, 1'b1};
    assign node_n = {node[TREE_DEPTH-2:0], leaf[level]};
    assign bkt_wr_en = state == BKT_CMP && |match;
    assign bkt_wdata = wdata;

    // Descending scan so the lowest-index match wins first_val; every match gets invalidated.
    always_comb begin
        match = '0;
        first_val = '0;
        wdata = bkt_rdata;
        for (int j = K - 1; j >= 0; j--) begin
            match[j] = assigned & bkt_rdata[j*TUPLE_W] & bkt_rdata[j*TUPLE_W+PE_BIT]
                     & (bkt_rdata[j*TUPLE_W+POS_LSB +: TREE_DEPTH-1] == leaf)
                     & (bkt_rdata[j*TUPLE_W+BN_LSB +: TREE_DEPTH] == rsp_block);
            if (match[j]) begin
                wdata[j*TUPLE_W] = 1'b0;
                first_val = bkt_rdata[j*TUPLE_W+2 +: VAL_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lfsr <= LFSR_SEED;
            pm_rd_en <= 1'b0;
            pm_wr_en <= 1'b0;
            bkt_rd_en <= 1'b0;
            pm_addr <= '0;
            bkt_addr <= '0;
            rsp_valid <= 1'b0;
            rsp_hit <= 1'b0;
            rsp_val <= '0;
            rsp_block <= '0;
            rsp_new_pos <= '0;
            leaf <= '0;
            node <= '0;
            level <= '0;
            assigned <= 1'b0;
`ifdef ORAM_FETCH_STATS_EN
            stat_hits <= '0;
            stat_misses <= '0;
`endif
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            pm_rd_en <= 1'b0;
            pm_wr_en <= 1'b0;
            bkt_rd_en <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    rsp_block <= req_block;
                    pm_addr <= req_block;
                    rsp_hit <= 1'b0;
                    rsp_val <= '0;
                    pm_rd_en <= 1'b1;
                    state <= PM_RD;
                end
                PM_RD: state <= PM_DATA;
                PM_DATA: begin
                    // An unmapped block still walks a random path so timing does not reveal it.
                    assigned <= pm_rdata[0];
                    leaf <= pm_rdata[0] ? pm_rdata[TREE_DEPTH-1:1] : lfsr[TREE_DEPTH-2:0];
                    rsp_new_pos <= lfsr[TREE_DEPTH-2:0];
                    node <= ROOT;
                    level <= '0;
                    bkt_addr <= '0;
                    bkt_rd_en <= 1'b1;
                    state <= BKT_RD;
                end
                BKT_RD: state <= BKT_CMP;
                BKT_CMP: begin
                    if (|match && !rsp_hit) begin
                        rsp_hit <= 1'b1;
                        rsp_val <= first_val;
                    end
                    if (level == LAST) begin
                        pm_wr_en <= 1'b1;
                        state <= PM_WR;
                    end else begin
                        node <= node_n;
                        bkt_addr <= node_n - 1'b1;
                        level <= level + 1'b1;
                        bkt_rd_en <= 1'b1;
                        state <= BKT_RD;
                    end
                end
                PM_WR: begin
                    rsp_valid <= 1'b1;
                    state <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef ORAM_FETCH_STATS_EN
            if (state == RESP && rsp_ready) begin
                if (rsp_hit && stat_hits != '1) stat_hits <= stat_hits + 1'b1;
                if (!rsp_hit && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
            end
`endif
        end
    end
endmodule
